// File: rtl/time_set_pkg.sv
// Shared types, output codes and value limits for the time/reminder setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    COMMIT_TIME,
    EDIT_REMIND,
    COMMIT_REMIND
  } state_e;

  localparam logic [1:0] SET_RUN    = 2'b00;
  localparam logic [1:0] SET_TIME   = 2'b01;
  localparam logic [1:0] SET_REMIND = 2'b10;

  localparam logic [1:0] FIELD_NONE   = 2'b00;
  localparam logic [1:0] FIELD_HOUR   = 2'b01;
  localparam logic [1:0] FIELD_MIN    = 2'b10;
  localparam logic [1:0] FIELD_REMIND = 2'b11;

  localparam logic [5:0] HOUR_MAX       = 6'd23;
  localparam logic [5:0] MIN_MAX        = 6'd59;
  localparam logic [5:0] REMIND_MIN     = 6'd1;
  localparam logic [5:0] REMIND_DEFAULT = 6'd10;

  // One wrapping step within [lo, hi]; simultaneous up and down cancel.
  function automatic logic [5:0] step_val(input logic [5:0] v, input logic [5:0] lo,
                                          input logic [5:0] hi, input logic up,
                                          input logic dn);
    logic [5:0] r;
    r = v;
    if (up && !dn) r = (v >= hi) ? lo : v + 6'd1;
    else if (dn && !up) r = (v <= lo) ? hi : v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw button and emits a single-cycle pulse when the accepted level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          last_q, last_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    last_d   = stable_q;
    press_d  = stable_q & ~last_q;
    // Any return to the accepted level restarts the stability window.
    if (btn_raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = btn_raw;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      last_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      last_q   <= last_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Three-button clock/reminder setting FSM: edits hour, minute and reminder hour, then
// holds a load code on set_all_times for the running clock to pick up.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 2_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [1:0] set_all_times,
  output logic [5:0] btn_time_set,
  output logic [5:0] btn_min_set,
  output logic [1:0] edit_field,
  output logic       busy
);

  localparam int unsigned CNT_W = 32;

  logic set_p, inc_p, dec_p, any_press, editing;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk(clk), .reset(reset), .btn_raw(btn_set), .press(set_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .btn_raw(btn_inc), .press(inc_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk(clk), .reset(reset), .btn_raw(btn_dec), .press(dec_p));

  state_e           state_q, state_d;
  logic [5:0]       hour_q, hour_d, min_q, min_d, remind_q, remind_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, idle_cnt_q, idle_cnt_d;
  logic [1:0]       sat_q, sat_d, field_q, field_d;
  logic             busy_q, busy_d;
  logic [5:0]       time_out_q, time_out_d, min_out_q, min_out_d;

  assign any_press = set_p | inc_p | dec_p;
  assign editing   = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN) ||
                     (state_q == EDIT_REMIND);

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    remind_d   = remind_q;
    hold_cnt_d = '0;
    idle_cnt_d = '0;
    if (power_on) begin
      unique case (state_q)
        IDLE: begin
          if (set_p) begin
            state_d = EDIT_HOUR;
            hour_d  = cur_hour;
            min_d   = cur_minute;
          end
        end
        EDIT_HOUR: begin
          hour_d = step_val(hour_q, 6'd0, HOUR_MAX, inc_p, dec_p);
          if (set_p) state_d = EDIT_MIN;
        end
        EDIT_MIN: begin
          min_d = step_val(min_q, 6'd0, MIN_MAX, inc_p, dec_p);
          if (set_p) state_d = COMMIT_TIME;
        end
        COMMIT_TIME: begin
          if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = EDIT_REMIND;
          else hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        EDIT_REMIND: begin
          remind_d = step_val(remind_q, REMIND_MIN, HOUR_MAX, inc_p, dec_p);
          if (set_p) state_d = COMMIT_REMIND;
        end
        COMMIT_REMIND: begin
          if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = IDLE;
          else hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
      // Abandon an edit after a long stretch with no button activity.
      if (editing && !any_press) begin
        if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
        else idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    sat_d      = SET_RUN;
    field_d    = FIELD_NONE;
    busy_d     = (state_d != IDLE);
    min_out_d  = min_q;
    time_out_d = hour_q;
    if ((state_q == EDIT_REMIND) || (state_q == COMMIT_REMIND)) time_out_d = remind_q;
    unique case (state_d)
      EDIT_HOUR:     field_d = FIELD_HOUR;
      EDIT_MIN:      field_d = FIELD_MIN;
      EDIT_REMIND:   field_d = FIELD_REMIND;
      COMMIT_TIME:   sat_d   = SET_TIME;
      COMMIT_REMIND: sat_d   = SET_REMIND;
      default:       field_d = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hour_q     <= '0;
      min_q      <= '0;
      remind_q   <= REMIND_DEFAULT;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
      sat_q      <= SET_RUN;
      field_q    <= FIELD_NONE;
      busy_q     <= 1'b0;
      time_out_q <= '0;
      min_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      remind_q   <= remind_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      sat_q      <= sat_d;
      field_q    <= field_d;
      busy_q     <= busy_d;
      time_out_q <= time_out_d;
      min_out_q  <= min_out_d;
    end
  end

  assign set_all_times = sat_q;
  assign edit_field    = field_q;
  assign busy          = busy_q;
  assign btn_time_set  = time_out_q;
  assign btn_min_set   = min_out_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce, hold and timeout parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset, power_on, btn_set, btn_inc, btn_dec;
  logic [5:0] cur_hour, cur_minute;
  logic [1:0] set_all_times, edit_field;
  logic [5:0] btn_time_set, btn_min_set;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit watch01 = 1'b0;
  bit saw01 = 1'b0;

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .power_on(power_on),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_minute(cur_minute),
    .set_all_times(set_all_times), .btn_time_set(btn_time_set),
    .btn_min_set(btn_min_set), .edit_field(edit_field), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch01 && set_all_times == 2'b01) saw01 = 1'b1;

  typedef struct {
    logic [5:0] ch, cm;
    logic       s, i, d;
    logic [1:0] f;
    logic       b;
    logic [5:0] t, m;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input int ch, input int cm, input int s, input int i,
                              input int d, input int f, input int b, input int t,
                              input int m);
    vec_t v;
    v.ch = 6'(ch); v.cm = 6'(cm);
    v.s = 1'(s); v.i = 1'(i); v.d = 1'(d);
    v.f = 2'(f); v.b = 1'(b); v.t = 6'(t); v.m = 6'(m);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic press(input logic s, input logic i, input logic d);
    btn_set = s; btn_inc = i; btn_dec = d;
    tick(6);
    btn_set = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(6);
  endtask

  task automatic apply(input int k);
    cur_hour = vecs[k].ch;
    cur_minute = vecs[k].cm;
    press(vecs[k].s, vecs[k].i, vecs[k].d);
    chk($sformatf("v%0d_field", k), edit_field, vecs[k].f);
    chk($sformatf("v%0d_busy", k), busy, vecs[k].b);
    chk($sformatf("v%0d_time", k), btn_time_set, vecs[k].t);
    chk($sformatf("v%0d_min", k), btn_min_set, vecs[k].m);
  endtask

  task automatic wait_code(input logic [1:0] code, output bit ok);
    int n = 0;
    while (set_all_times != code && n < 20) begin
      tick(1);
      n++;
    end
    ok = (set_all_times == code);
  endtask

  task automatic commit(input logic [1:0] code, input int t, input int m, input string tag);
    bit ok;
    int n;
    btn_set = 1'b1;
    wait_code(code, ok);
    chk({tag, "_start"}, int'(ok), 1);
    btn_set = 1'b0;
    chk({tag, "_time"}, btn_time_set, t);
    chk({tag, "_min"}, btn_min_set, m);
    chk({tag, "_field"}, edit_field, 0);
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (set_all_times == code && n < 20) begin
      n++;
      tick(1);
    end
    chk({tag, "_len"}, n, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int r;

    vecs[0]  = mk(12, 34, 0, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(12, 34, 1, 0, 0, 1, 1, 12, 34);
    vecs[2]  = mk(12, 34, 0, 1, 0, 1, 1, 13, 34);
    vecs[3]  = mk(12, 34, 0, 1, 0, 1, 1, 14, 34);
    vecs[4]  = mk(12, 34, 0, 1, 1, 1, 1, 14, 34);
    vecs[5]  = mk(12, 34, 1, 0, 0, 2, 1, 14, 34);
    vecs[6]  = mk(12, 34, 0, 0, 1, 2, 1, 14, 33);
    vecs[7]  = mk(23, 0, 1, 0, 0, 1, 1, 23, 0);
    vecs[8]  = mk(23, 0, 0, 1, 0, 1, 1, 0, 0);
    vecs[9]  = mk(23, 0, 0, 0, 1, 1, 1, 23, 0);
    vecs[10] = mk(23, 0, 0, 1, 0, 1, 1, 0, 0);
    vecs[11] = mk(23, 0, 1, 0, 0, 2, 1, 0, 0);
    vecs[12] = mk(23, 0, 0, 0, 1, 2, 1, 0, 59);
    vecs[13] = mk(23, 0, 0, 1, 1, 2, 1, 0, 59);
    vecs[14] = mk(23, 0, 0, 1, 0, 2, 1, 0, 0);
    vecs[15] = mk(23, 0, 0, 0, 1, 2, 1, 0, 59);

    reset = 1'b1; power_on = 1'b1;
    btn_set = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hour = 6'd12; cur_minute = 6'd34;
    tick(3);
    reset = 1'b0;
    chk("rst_sat", set_all_times, 0);
    chk("rst_field", edit_field, 0);
    chk("rst_busy", busy, 0);
    chk("rst_time", btn_time_set, 0);
    chk("rst_min", btn_min_set, 0);

    // Time edit 12:34 -> 14:33, including ignored IDLE inc and cancelling inc+dec
    for (int k = 0; k <= 6; k++) apply(k);
    commit(2'b01, 14, 33, "ct");
    chk("ct_after_field", edit_field, 3);
    chk("ct_after_busy", busy, 1);
    chk("ct_after_sat", set_all_times, 0);
    tick(2);
    chk("remind_default", btn_time_set, 10);

    // Reminder 10 down by ten presses wraps through 1 to 23
    r = 10;
    for (int k = 0; k < 10; k++) begin
      press(1'b0, 1'b0, 1'b1);
      r = (r == 1) ? 23 : r - 1;
      chk($sformatf("rem_dec%0d", k), btn_time_set, r);
    end
    commit(2'b10, 23, 33, "cr");
    chk("cr_after_field", edit_field, 0);
    chk("cr_after_busy", busy, 0);
    chk("cr_after_sat", set_all_times, 0);

    // Hour and minute wrap boundaries
    for (int k = 7; k <= 15; k++) apply(k);

    // Inactivity timeout in EDIT_MIN
    watch01 = 1'b1;
    tick(50);
    chk("to_early_busy", busy, 1);
    tick(20);
    chk("to_busy", busy, 0);
    chk("to_field", edit_field, 0);
    watch01 = 1'b0;
    chk("to_no_commit", int'(saw01), 0);
    chk("to_keep_min", btn_min_set, 59);

    // Glitch rejected; bounce then stable yields exactly one press
    cur_hour = 6'd7; cur_minute = 6'd45;
    btn_set = 1'b1; tick(2); btn_set = 1'b0; tick(10);
    chk("glitch_busy", busy, 0);
    chk("glitch_field", edit_field, 0);
    btn_set = 1'b1; tick(2); btn_set = 1'b0; tick(1);
    btn_set = 1'b1; tick(5);
    chk("deb_early", edit_field, 0);
    tick(1);
    chk("deb_on_time", edit_field, 1);
    tick(6); btn_set = 1'b0; tick(8);
    chk("bounce_one_press", edit_field, 1);
    chk("bounce_time", btn_time_set, 7);
    chk("bounce_min", btn_min_set, 45);

    // Power loss in cycle 3 of COMMIT_TIME
    press(1'b1, 1'b0, 1'b0);
    btn_set = 1'b1;
    wait_code(2'b01, ok);
    chk("pw_start", int'(ok), 1);
    tick(2);
    chk("pw_cycle3", set_all_times, 1);
    power_on = 1'b0;
    tick(1);
    chk("pw_sat", set_all_times, 0);
    chk("pw_busy", busy, 0);
    chk("pw_field", edit_field, 0);
    btn_set = 1'b0; power_on = 1'b1;
    tick(8);
    chk("pw_keep_time", btn_time_set, 7);
    chk("pw_keep_min", btn_min_set, 45);

    // Reset in cycle 3 of COMMIT_TIME
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    btn_set = 1'b1;
    wait_code(2'b01, ok);
    chk("rs_start", int'(ok), 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rs_sat", set_all_times, 0);
    chk("rs_busy", busy, 0);
    chk("rs_field", edit_field, 0);
    chk("rs_time", btn_time_set, 0);
    reset = 1'b0; btn_set = 1'b0;
    tick(8);
    chk("rs_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
